// File: rtl/out_ser_tx_if.sv
// Sample/strobe inputs and serial/status outputs of the stereo output serializer.
// The master side feeds sample pairs and frame strobes; the slave side is the serializer.
interface out_ser_tx_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] outL;
  logic [WIDTH-1:0] outR;
  logic             out_valid;
  logic             Frame;
  logic             OutputL;
  logic             OutputR;
  logic             OutReady;
  logic             buf_full;
  logic             overrun;
  logic             underrun;
  logic             frame_err;

  modport master (
    output outL, outR, out_valid, Frame,
    input  OutputL, OutputR, OutReady, buf_full, overrun, underrun, frame_err
  );

  modport slave (
    input  outL, outR, out_valid, Frame,
    output OutputL, OutputR, OutReady, buf_full, overrun, underrun, frame_err
  );
endinterface

// File: rtl/out_ser_tx.sv
// Stereo output serializer: buffers left/right sample pairs in a small FIFO and
// shifts one pair out MSB-first on two serial lines per frame strobe.
module out_ser_tx #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic        Sclk,
  input  logic        Reset_n,
  input  logic        clear,
  out_ser_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]    count_q, count_d;
  logic             buf_full_q;
  logic             overrun_q, underrun_q, frame_err_q;
  logic [WIDTH-1:0] mem_l [DEPTH];
  logic [WIDTH-1:0] mem_r [DEPTH];

  logic last_bit, can_pop, buf_empty, pop, push;

  // A frame is accepted while idle or on the final bit cycle, giving gapless words.
  assign last_bit  = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
  assign can_pop   = (state_q == IDLE) || last_bit;
  assign buf_empty = (count_q == '0);
  assign pop       = bus.Frame && can_pop && !buf_empty;
  assign push      = bus.out_valid && ((count_q != FULL_CNT) || pop);

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_l_d    = sh_l_q;
    sh_r_d    = sh_r_q;
    count_d   = count_q;

    if (state_q == SHIFT) begin
      sh_l_d    = {sh_l_q[WIDTH-2:0], 1'b0};
      sh_r_d    = {sh_r_q[WIDTH-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (last_bit) state_d = IDLE;
    end

    if (pop) begin
      sh_l_d    = mem_l[rd_ptr_q];
      sh_r_d    = mem_r[rd_ptr_q];
      bit_cnt_d = '0;
      state_d   = SHIFT;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      buf_full_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      buf_full_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
      count_q    <= count_d;
      buf_full_q <= (count_d == FULL_CNT);
      if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      if (bus.out_valid && !push)            overrun_q   <= 1'b1;
      if (bus.Frame && can_pop && buf_empty) underrun_q  <= 1'b1;
      if (bus.Frame && !can_pop)             frame_err_q <= 1'b1;
    end
  end

  // NOTE: sample storage is not reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge Sclk) begin
    if (push && !clear) begin
      mem_l[wr_ptr_q] <= bus.outL;
      mem_r[wr_ptr_q] <= bus.outR;
    end
  end

  assign bus.OutReady  = (state_q == SHIFT);
  assign bus.OutputL   = bus.OutReady & sh_l_q[WIDTH-1];
  assign bus.OutputR   = bus.OutReady & sh_r_q[WIDTH-1];
  assign bus.buf_full  = buf_full_q;
  assign bus.overrun   = overrun_q;
  assign bus.underrun  = underrun_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_out_ser_tx.sv
// Self-checking bench for out_ser_tx: directed scenarios plus random traffic,
// compared every cycle against a queue-based transaction model.
module tb_out_ser_tx;
  localparam int W = 16;
  localparam int D = 2;

  logic sclk;
  logic reset_n;
  logic clear;

  out_ser_tx_if #(.WIDTH(W)) bus ();

  out_ser_tx #(.WIDTH(W), .DEPTH(D)) dut (
    .Sclk    (sclk),
    .Reset_n (reset_n),
    .clear   (clear),
    .bus     (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int checks   = 0;
  int failures = 0;

  // Model: FIFO of pairs, the word on the line and how many of its bits remain.
  logic [2*W-1:0] q[$];
  logic [W-1:0]   cur_l, cur_r;
  int             rem;
  bit             m_over, m_under, m_ferr;

  logic [63:0] cap_l, cap_r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rem     = 0;
    cur_l   = '0;
    cur_r   = '0;
    m_over  = 0;
    m_under = 0;
    m_ferr  = 0;
  endtask

  task automatic model_edge(input bit v, input logic [W-1:0] l, input logic [W-1:0] r,
                            input bit f, input bit c);
    bit popped;
    if (c) begin
      model_reset();
      return;
    end
    popped = 0;
    if (f) begin
      if (rem <= 1) begin
        if (q.size() > 0) begin
          {cur_l, cur_r} = q.pop_front();
          rem    = W;
          popped = 1;
        end else begin
          m_under = 1;
        end
      end else begin
        m_ferr = 1;
      end
    end
    if (!popped && rem > 0) rem--;
    if (v) begin
      if (q.size() < D) q.push_back({l, r});
      else              m_over = 1;
    end
  endtask

  function automatic logic [6:0] model_outs();
    logic ready, bl, br;
    ready = (rem > 0);
    bl    = ready ? cur_l[rem-1] : 1'b0;
    br    = ready ? cur_r[rem-1] : 1'b0;
    return {ready, bl, br, 1'(q.size() == D), m_over, m_under, m_ferr};
  endfunction

  function automatic logic [6:0] dut_outs();
    return {bus.OutReady, bus.OutputL, bus.OutputR, bus.buf_full,
            bus.overrun, bus.underrun, bus.frame_err};
  endfunction

  // Called at a falling edge: drive inputs, take one rising edge, compare at the next falling edge.
  task automatic cycle(input bit v, input logic [W-1:0] l, input logic [W-1:0] r,
                       input bit f, input bit c, input string tag);
    bus.out_valid = v;
    bus.outL      = l;
    bus.outR      = r;
    bus.Frame     = f;
    clear         = c;
    @(posedge sclk);
    model_edge(v, l, r, f, c);
    @(negedge sclk);
    check(tag, 64'(dut_outs()), 64'(model_outs()));
    if (bus.OutReady === 1'b1) begin
      cap_l = {cap_l[62:0], bus.OutputL};
      cap_r = {cap_r[62:0], bus.OutputR};
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, 0, tag);
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r, input string tag);
    cycle(1, l, r, 0, 0, tag);
  endtask

  task automatic frame(input string tag);
    cycle(0, '0, '0, 1, 0, tag);
  endtask

  task automatic do_clear();
    cycle(0, '0, '0, 0, 1, "clear");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    clear         = 1'b0;
    bus.out_valid = 1'b0;
    bus.Frame     = 1'b0;
    bus.outL      = '0;
    bus.outR      = '0;
    cap_l         = '0;
    cap_r         = '0;
    model_reset();
    #3;
    check("reset_outs", 64'(dut_outs()), 64'(0));
    @(negedge sclk);
    @(negedge sclk);
    reset_n = 1'b1;

    // Single word with known bit pattern.
    push(16'hA5C3, 16'h0F0F, "wr_a5c3");
    frame("frame_a5c3");
    idle(17, "shift_a5c3");
    check("word_a5c3_L", {48'b0, cap_l[15:0]}, 64'h0000_0000_0000_A5C3);
    check("word_a5c3_R", {48'b0, cap_r[15:0]}, 64'h0000_0000_0000_0F0F);

    // Fill, overflow, then drain two words.
    push(16'h1111, ~16'h1111, "wr_1111");
    push(16'h2222, ~16'h2222, "wr_2222");
    check("full_after_2", 64'(bus.buf_full), 64'(1));
    push(16'h3333, ~16'h3333, "wr_3333");
    check("overrun_after_3", 64'(bus.overrun), 64'(1));
    frame("frame_1111");
    idle(16, "shift_1111");
    frame("frame_2222");
    idle(17, "shift_2222");
    check("drain_L", {32'b0, cap_l[31:0]}, 64'h0000_0000_1111_2222);
    check("drain_R", {32'b0, cap_r[31:0]}, {32'b0, ~16'h1111, ~16'h2222});
    frame("frame_empty_after_drain");
    check("no_third_word", 64'(bus.OutReady), 64'(0));

    // Underrun on empty buffer.
    do_clear();
    check("clear_flags", 64'(dut_outs()), 64'(0));
    frame("frame_empty");
    check("underrun_set", 64'(bus.underrun), 64'(1));
    idle(2, "after_underrun");

    // Frame mid-shift is ignored.
    do_clear();
    push(16'hBEEF, 16'h1234, "wr_beef");
    push(16'hCAFE, 16'h5678, "wr_cafe");
    frame("frame_beef");
    idle(4, "shift_beef_a");
    frame("frame_midshift");
    check("frame_err_set", 64'(bus.frame_err), 64'(1));
    idle(12, "shift_beef_b");
    check("word_beef_L", {48'b0, cap_l[15:0]}, 64'h0000_0000_0000_BEEF);
    idle(1, "beef_done");
    push(16'hD00D, 16'h9999, "wr_d00d");
    check("count_unchanged_full", 64'(bus.buf_full), 64'(1));
    frame("frame_cafe");
    idle(17, "shift_cafe");
    check("word_cafe_R", {48'b0, cap_r[15:0]}, 64'h0000_0000_0000_5678);

    // Same-edge pop and write with the buffer full.
    do_clear();
    push(16'h5555, 16'h0001, "wr_5555");
    push(16'h6666, 16'h0002, "wr_6666");
    cycle(1, 16'h4444, 16'h0003, 1, 0, "pop_and_wr_4444");
    check("same_edge_no_overrun", 64'(bus.overrun), 64'(0));
    check("same_edge_still_full", 64'(bus.buf_full), 64'(1));
    idle(15, "shift_5555");
    frame("frame_6666");
    idle(15, "shift_6666");
    frame("frame_4444");
    idle(17, "shift_4444");
    check("order_L", {16'b0, cap_l[47:0]}, 64'h0000_5555_6666_4444);

    // Same-edge write into an empty buffer: pop refused.
    do_clear();
    cycle(1, 16'h7A7A, 16'h0A0A, 1, 0, "empty_wr_and_frame");
    check("empty_same_edge_underrun", 64'(bus.underrun), 64'(1));
    frame("frame_7a7a");
    idle(16, "shift_7a7a");
    check("word_7a7a", {48'b0, cap_l[15:0]}, 64'h0000_0000_0000_7A7A);

    // Asynchronous reset mid-shift.
    do_clear();
    push(16'hFFFF, 16'hFFFF, "wr_ffff");
    frame("frame_ffff");
    idle(7, "shift_ffff");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outs", 64'(dut_outs()), 64'(0));
    model_reset();
    @(negedge sclk);
    reset_n = 1'b1;
    frame("frame_after_reset");
    check("underrun_after_reset", 64'(bus.underrun), 64'(1));

    // Random traffic against the model.
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      bit v, f, c;
      v = ($urandom_range(0, 99) < 40);
      f = ($urandom_range(0, 99) < 12);
      c = ($urandom_range(0, 199) < 3);
      cycle(v, W'($urandom), W'($urandom), f, c, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/out_ser_tx.md
# out_ser_tx

Stereo output serializer for the audio processor's transmit side. It accepts processed left/right 16-bit sample pairs from the filter datapath into a 2-deep buffer. On each frame strobe it shifts one pair out MSB-first on two serial lines, one per channel, with a qualifying `OutReady` strobe. It mirrors the input capture path: input frames are deserialized into sample memory, and this block serializes results back out at the same frame rate.

## Interface

Parameters:
- `WIDTH`, 16: sample width in bits; also the number of shift cycles per frame.
- `DEPTH`, 2: buffer depth in stereo pairs; must be a power of two.

Ports:
- `Sclk` in 1: system clock; all logic is on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush.
- `outL` in WIDTH: processed left sample.
- `outR` in WIDTH: processed right sample.
- `out_valid` in 1: one-cycle strobe; writes the pair {`outL`, `outR`} into the buffer.
- `Frame` in 1: one-cycle frame-start strobe; requests transmission of one pair.
- `OutputL` out 1: left serial data, MSB first.
- `OutputR` out 1: right serial data, MSB first.
- `OutReady` out 1: high while `OutputL`/`OutputR` carry valid bits.
- `buf_full` out 1: buffer holds DEPTH pairs.
- `overrun` out 1: sticky; an `out_valid` arrived while the buffer was full.
- `underrun` out 1: sticky; a `Frame` arrived with the buffer empty.
- `frame_err` out 1: sticky; a `Frame` arrived while shifting.

## Operation

- Buffer: circular FIFO of DEPTH pairs with write pointer, read pointer and count (range 0..DEPTH).
  - Write occurs on `out_valid` when not full.
  - `out_valid` when full: the pair is dropped, contents are unchanged, `overrun` is set.
- State machine: IDLE and SHIFT, plus a bit counter of width clog2(WIDTH)+1.
- IDLE:
  - `Frame`=1 and count>0: pop the head pair into `shL`/`shR`, counter=0, go to SHIFT.
  - `Frame`=1 and count=0: set `underrun`, stay in IDLE, outputs stay 0.
- SHIFT:
  - Each edge shifts `shL`/`shR` left by one, zero-filling, and increments the counter.
  - After the bit-(WIDTH-1) cycle completes, go to IDLE.
  - `Frame` in SHIFT: ignored (no pop, no restart), `frame_err` set.
- `OutputL`/`OutputR` are `shL[WIDTH-1]`/`shR[WIDTH-1]` while `OutReady`=1, and 0 otherwise.
- Same-edge write and pop: both take effect and count is unchanged.
  - With count=DEPTH, a pop on the same edge frees a slot, so that write is accepted and is not an overrun.
  - With count=0, the pop is refused (underrun) even if a write arrives on the same edge; the written pair becomes available at the next `Frame`.
- `clear` (synchronous, takes priority over all other inputs): pointers and count go to 0, SHIFT is aborted to IDLE, shift registers go to 0, all sticky flags are cleared.
- Reset (`Reset_n`=0, asynchronous): identical state to `clear`.
  - Reset values: `OutputL`=0, `OutputR`=0, `OutReady`=0, `buf_full`=0, `overrun`=0, `underrun`=0, `frame_err`=0.

## Timing

- Edge T0 samples `Frame`=1 with data available. From T0 through edge T0+WIDTH, `OutReady`=1 for exactly WIDTH cycles.
  - Cycle k after T0 (k=0..WIDTH-1) carries bit WIDTH-1-k on each line.
  - Latency from `Frame` to MSB on the line: 1 edge.
- `OutReady` falls at edge T0+WIDTH. A `Frame` sampled at that same edge is accepted and starts the next word back-to-back, with no gap.
- A pair written at edge T is poppable by a `Frame` sampled at edge T+1 or later.
- `buf_full` is registered and reflects count after each edge.
- Sticky flags assert at the edge that samples the offending event.
- Reset asserted mid-shift: outputs go to 0 immediately (asynchronously). The first transmission after release needs a fresh `out_valid` followed by a `Frame`.

## Test plan

- Write L=0xA5C3, R=0x0F0F, then `Frame`: `OutReady` is high for 16 cycles. `OutputL` carries 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 and `OutputR` carries 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1. Afterwards both lines are 0 and `OutReady`=0.
- Write 3 pairs (0x1111, 0x2222, 0x3333) with no `Frame`: `buf_full`=1 after the second write and `overrun`=1 after the third. Two `Frame`s then emit 0x1111 and 0x2222 only.
- `Frame` with the buffer empty: `underrun`=1, `OutReady` stays 0.
- `Frame` at cycle 5 of a shift: the word completes unaltered, `frame_err`=1, and the buffer count is unchanged.
- Buffer full while a `Frame` pops and an `out_valid` (0x4444) writes on the same edge: no overrun, count stays 2, and 0x4444 is emitted third.
- `Reset_n` low at cycle 8 of a shift: `OutReady`, `OutputL` and `OutputR` go to 0 without waiting for a clock, and all flags are 0. After release, a `Frame` gives `underrun`=1.
